// File: rtl/spectrum_capture_if.sv
// Bus between the capture sequencer, the sdft core and the display BRAM.
interface spectrum_capture_if #(
   parameter int DATA_W = 8,
   parameter int FREQ_W = 16,
   parameter int ADDR_W = 4,
   parameter int OUT_W  = 10
);
   logic                     sdft_ready;
   logic                     sdft_start;
   logic [DATA_W-1:0]        sdft_sample;
   logic                     sdft_read;
   logic [ADDR_W-1:0]        sdft_bin_addr;
   logic signed [FREQ_W-1:0] sdft_real;
   logic signed [FREQ_W-1:0] sdft_imag;
   logic                     bram_w_en;
   logic [ADDR_W-1:0]        bram_w_addr;
   logic [OUT_W-1:0]         bram_w_data;
   logic                     frame_done;

   modport master (
      input  sdft_ready, sdft_real, sdft_imag,
      output sdft_start, sdft_sample, sdft_read, sdft_bin_addr,
      output bram_w_en, bram_w_addr, bram_w_data, frame_done
   );

   modport slave (
      output sdft_ready, sdft_real, sdft_imag,
      input  sdft_start, sdft_sample, sdft_read, sdft_bin_addr,
      input  bram_w_en, bram_w_addr, bram_w_data, frame_done
   );
endinterface

// File: rtl/spectrum_capture.sv
// Feeds ADC samples to the sdft, reads bins while blanked and writes
// post-processed power (instant / peak-hold / average) to the BRAM.
module spectrum_capture #(
   parameter int DATA_W        = 8,
   parameter int FREQ_W        = 16,
   parameter int BINS          = 16,
   parameter int ADDR_W        = 4,
   parameter int OUT_W         = 10,
   parameter int POWER_SHIFT   = 8,
   parameter int UPDATE_PERIOD = 64,
   parameter int AVG_SHIFT     = 2,
   parameter int DECAY         = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] adc_sample,
   input  logic              blank,
   input  logic [1:0]        mode,
   spectrum_capture_if.master bus
);

   localparam int CNT_W  = $clog2(UPDATE_PERIOD + 1);
   localparam int PROD_W = 2 * FREQ_W;
   localparam int SUM_W  = 2 * FREQ_W + 1;
   localparam logic [OUT_W-1:0]  P_MAX    = '1;
   localparam logic [OUT_W-1:0]  DEC      = OUT_W'(DECAY);
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(BINS - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);

   typedef enum logic [2:0] {
      WAIT_READY, START, WAIT_BUSY, PROCESS, READ, CALC, WRITE
   } state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   sample_q;
   logic                start_q;
   logic                read_q;
   logic                wen_q;
   logic                frame_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [OUT_W-1:0]    p_q;
   logic [OUT_W-1:0]    hist_q [BINS];

   logic signed [PROD_W-1:0] re_x, im_x, re2, im2;
   logic [SUM_W-1:0]         pwr_sum, pwr_shr;
   logic [OUT_W-1:0]         p_d;

   // Products are non-negative, so the sum is exact at 2*FREQ_W+1 bits
   always_comb begin
      re_x    = PROD_W'(bus.sdft_real);
      im_x    = PROD_W'(bus.sdft_imag);
      re2     = re_x * re_x;
      im2     = im_x * im_x;
      pwr_sum = {1'b0, re2} + {1'b0, im2};
      pwr_shr = pwr_sum >> POWER_SHIFT;
      p_d     = (|pwr_shr[SUM_W-1:OUT_W]) ? P_MAX : pwr_shr[OUT_W-1:0];
   end

   logic [OUT_W-1:0]  hist_sel, dec_v, new_v;
   logic signed [OUT_W:0] diff_v, avg_v;

   always_comb begin
      hist_sel = hist_q[addr_q];
      dec_v    = (hist_sel >= DEC) ? hist_sel - DEC : '0;
      diff_v   = $signed({1'b0, p_q}) - $signed({1'b0, hist_sel});
      avg_v    = $signed({1'b0, hist_sel}) + (diff_v >>> AVG_SHIFT);
      new_v    = p_q;
      case (mode)
         2'd1:    new_v = (p_q > dec_v) ? p_q : dec_v;
         2'd2:    new_v = avg_v[OUT_W] ? '0 : avg_v[OUT_W-1:0];
         default: new_v = p_q;
      endcase
   end

   assign bus.sdft_start    = start_q;
   assign bus.sdft_sample   = sample_q;
   assign bus.sdft_read     = read_q;
   assign bus.sdft_bin_addr = addr_q;
   assign bus.bram_w_en     = wen_q;
   assign bus.bram_w_addr   = addr_q;
   assign bus.bram_w_data   = wen_q ? new_v : '0;
   assign bus.frame_done    = frame_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= WAIT_READY;
         sample_q <= '0;
         start_q  <= 1'b0;
         read_q   <= 1'b0;
         wen_q    <= 1'b0;
         frame_q  <= 1'b0;
         addr_q   <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
         for (int i = 0; i < BINS; i++) hist_q[i] <= '0;
      end else begin
         unique case (state_q)
            WAIT_READY: if (bus.sdft_ready) begin
               sample_q <= adc_sample;
               start_q  <= 1'b1;
               state_q  <= START;
            end
            START: state_q <= WAIT_BUSY;
            WAIT_BUSY: if (!bus.sdft_ready) begin
               start_q <= 1'b0;
               state_q <= PROCESS;
            end
            // A due read held off by active video stays pending here
            PROCESS: if (bus.sdft_ready) begin
               if (cnt_q == CNT_LAST && blank) begin
                  cnt_q   <= '0;
                  read_q  <= 1'b1;
                  state_q <= READ;
               end else begin
                  if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
                  state_q <= WAIT_READY;
               end
            end
            READ: begin
               read_q  <= 1'b0;
               state_q <= CALC;
            end
            CALC: begin
               p_q     <= p_d;
               wen_q   <= 1'b1;
               frame_q <= (addr_q == LAST);
               state_q <= WRITE;
            end
            WRITE: begin
               hist_q[addr_q] <= new_v;
               wen_q   <= 1'b0;
               frame_q <= 1'b0;
               addr_q  <= (addr_q == LAST) ? '0 : addr_q + 1'b1;
               state_q <= WAIT_READY;
            end
            default: state_q <= WAIT_READY;
         endcase
      end
   end

endmodule

// File: tb/tb_spectrum_capture.sv
// Bench for spectrum_capture: table vectors, timing sequences and a
// randomized run against an arithmetic reference model.
module tb_spectrum_capture;
   localparam int DATA_W = 8;
   localparam int FREQ_W = 16;
   localparam int BINS   = 16;
   localparam int ADDR_W = 4;
   localparam int OUT_W  = 10;
   localparam int UP     = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [DATA_W-1:0] adc;
   logic              blank;
   logic [1:0]        mode;
   logic signed [FREQ_W-1:0] re_v, im_v;
   logic              rdy;
   int                busy;

   spectrum_capture_if #(
      .DATA_W(DATA_W), .FREQ_W(FREQ_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)
   ) bus ();

   spectrum_capture #(
      .DATA_W(DATA_W), .FREQ_W(FREQ_W), .BINS(BINS), .ADDR_W(ADDR_W),
      .OUT_W(OUT_W), .POWER_SHIFT(8), .UPDATE_PERIOD(UP),
      .AVG_SHIFT(2), .DECAY(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .adc_sample(adc),
      .blank(blank), .mode(mode), .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.sdft_ready = rdy;
   assign bus.sdft_real  = re_v;
   assign bus.sdft_imag  = im_v;

   // sdft stand-in: 4 cycles busy per accepted start
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdy  <= 1'b1;
         busy <= 0;
      end else if (busy != 0) begin
         busy <= busy - 1;
         if (busy == 1) rdy <= 1'b1;
      end else if (bus.sdft_start && rdy) begin
         rdy  <= 1'b0;
         busy <= 4;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
   endtask

   int cyc = 0, starts = 0, reads = 0, wens = 0;
   int v_hold = 0, v_width = 0, v_lat = 0, v_addr = 0, v_mix = 0;

   initial begin : monitor
      int run, rd_cyc;
      bit pend, p_start, p_read, p_wen;
      logic [ADDR_W-1:0] rd_addr;
      run = 0; rd_cyc = 0; pend = 0;
      p_start = 0; p_read = 0; p_wen = 0; rd_addr = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            pend = 0; run = 0; p_start = 0; p_read = 0; p_wen = 0;
         end else begin
            if (bus.sdft_start && !p_start) begin
               starts++;
               chk("start_sample", bus.sdft_sample, adc);
            end
            if (bus.sdft_start && !bus.sdft_ready) run++;
            else run = 0;
            if (run > 1) v_hold++;
            if ((bus.sdft_read && p_read) || (bus.bram_w_en && p_wen))
               v_width++;
            if (bus.frame_done && !bus.bram_w_en) v_width++;
            if (bus.sdft_start && (bus.sdft_read || bus.bram_w_en)) v_mix++;
            if (bus.sdft_read) begin
               reads++; rd_cyc = cyc; pend = 1;
               rd_addr = bus.sdft_bin_addr;
            end
            if (bus.bram_w_en && !p_wen) begin
               wens++;
               if (!pend || cyc - rd_cyc != 2) v_lat++;
               if (bus.bram_w_addr != rd_addr || bus.sdft_bin_addr != rd_addr)
                  v_addr++;
               pend = 0;
            end
            p_start = bus.sdft_start;
            p_read  = bus.sdft_read;
            p_wen   = bus.bram_w_en;
         end
      end
   end

   task automatic do_write(output logic [OUT_W-1:0] d,
                           output logic [ADDR_W-1:0] a, output logic f);
      int k;
      k = 0; d = '0; a = '0; f = 1'b0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.bram_w_en && k < 400);
      if (bus.bram_w_en) begin
         d = bus.bram_w_data; a = bus.bram_w_addr; f = bus.frame_done;
      end else chk("write_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_starts(input int target);
      int k;
      k = 0;
      while (starts < target && k < 2000) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (starts < target) chk("start_timeout", starts, target);
   endtask

   function automatic int model_p(input int r, input int i);
      longint s;
      s = longint'(r) * r + longint'(i) * i;
      s = s / 256;
      return (s > 1023) ? 1023 : int'(s);
   endfunction

   function automatic int model_new(input int m, input int p, input int h);
      int dv, df, st, nv;
      nv = p;
      if (m == 1) begin
         dv = (h - 1 < 0) ? 0 : h - 1;
         nv = (p > dv) ? p : dv;
      end else if (m == 2) begin
         df = p - h;
         st = (df >= 0) ? df / 4 : -((-df + 3) / 4);
         nv = h + st;
         if (nv < 0) nv = 0;
         if (nv > 1023) nv = 1023;
      end
      return nv;
   endfunction

   typedef struct {
      logic [1:0] m;
      int re;
      int im;
      int exp;
   } vec_t;

   vec_t tbl[15];

   initial begin : stim
      logic [OUT_W-1:0] d;
      logic [ADDR_W-1:0] a;
      logic f;
      int base_s, base_r, w0, k, ma, r, i, p, nv;
      int hm[BINS];

      tbl[0]  = '{2'd0, 160, 120, 156};
      tbl[1]  = '{2'd0, 32767, 32767, 1023};
      tbl[2]  = '{2'd0, 160, 120, 156};
      tbl[3]  = '{2'd1, 0, 0, 155};
      tbl[4]  = '{2'd1, 160, 160, 200};
      tbl[5]  = '{2'd0, 0, 0, 0};
      tbl[6]  = '{2'd2, 160, 120, 39};
      tbl[7]  = '{2'd2, 160, 120, 68};
      tbl[8]  = '{2'd2, 160, 120, 90};
      tbl[9]  = '{2'd3, 160, 120, 156};
      tbl[10] = '{2'd1, -160, -120, 156};
      tbl[11] = '{2'd2, 0, 0, 117};
      tbl[12] = '{2'd2, 32767, 0, 343};
      tbl[13] = '{2'd0, 0, 0, 0};
      tbl[14] = '{2'd1, 0, 0, 0};

      reset_n = 1'b0; blank = 1'b1; mode = 2'd0;
      adc = 8'h5A; re_v = '0; im_v = '0;
      repeat (3) @(negedge clk);
      chk("rst_start", bus.sdft_start, 0);
      chk("rst_sample", bus.sdft_sample, 0);
      chk("rst_read", bus.sdft_read, 0);
      chk("rst_bin_addr", bus.sdft_bin_addr, 0);
      chk("rst_wen", bus.bram_w_en, 0);
      chk("rst_waddr", bus.bram_w_addr, 0);
      chk("rst_wdata", bus.bram_w_data, 0);
      chk("rst_frame", bus.frame_done, 0);

      mode = tbl[0].m; re_v = 16'(tbl[0].re); im_v = 16'(tbl[0].im);
      @(posedge clk);
      #1 reset_n = 1'b1;

      for (int e = 0; e < 15; e++) begin
         mode = tbl[e].m;
         re_v = 16'(tbl[e].re);
         im_v = 16'(tbl[e].im);
         do_write(d, a, f);
         chk($sformatf("tbl%0d_data", e), d, tbl[e].exp);
         chk($sformatf("tbl%0d_addr", e), a, 0);
         chk($sformatf("tbl%0d_frame", e), f, 0);
         re_v = '0; im_v = '0;
         for (int b = 1; b < BINS; b++) begin
            do_write(d, a, f);
            chk("wrap_addr", a, b);
            chk("wrap_frame", f, (b == BINS - 1) ? 1 : 0);
         end
      end

      // Deferral: due read held off by active video, then taken once
      reset_n = 1'b0; blank = 1'b0; mode = 2'd0;
      re_v = 16'sd160; im_v = 16'sd120;
      repeat (3) @(posedge clk);
      base_s = starts; base_r = reads;
      #1 reset_n = 1'b1;
      wait_starts(base_s + 14);
      chk("blank_no_read", reads - base_r, 0);
      blank = 1'b1;
      adc = 8'hA5;
      wait_starts(base_s + 15);
      chk("blank_one_read", reads - base_r, 1);
      wait_starts(base_s + 18);
      chk("restart_no_read", reads - base_r, 1);
      wait_starts(base_s + 19);
      chk("restart_read", reads - base_r, 2);

      // Reset while in CALC abandons the write
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.sdft_read && k < 400);
      chk("calc_read_seen", bus.sdft_read, 1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      w0 = wens;
      @(negedge clk);
      chk("calc_rst_wen", bus.bram_w_en, 0);
      chk("calc_rst_start", bus.sdft_start, 0);
      chk("calc_rst_read", bus.sdft_read, 0);
      chk("calc_rst_sample", bus.sdft_sample, 0);
      chk("calc_rst_frame", bus.frame_done, 0);
      chk("calc_rst_wdata", bus.bram_w_data, 0);
      repeat (3) @(posedge clk);
      base_s = starts;
      #1 reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("calc_rst_no_write", wens - w0, 0);

      ma = 0;
      for (int b = 0; b < BINS; b++) hm[b] = 0;
      for (int n = 0; n < 48; n++) begin
         mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            r = int'($urandom_range(0, 65535)) - 32768;
            i = int'($urandom_range(0, 65535)) - 32768;
         end else begin
            r = int'($urandom_range(0, 600));
            i = int'($urandom_range(0, 600));
            if ($urandom_range(0, 1) == 1) r = -r;
            if ($urandom_range(0, 1) == 1) i = -i;
         end
         re_v = 16'(r);
         im_v = 16'(i);
         do_write(d, a, f);
         p  = model_p(r, i);
         nv = model_new(int'(mode), p, hm[ma]);
         chk($sformatf("rnd%0d_data", n), d, nv);
         chk($sformatf("rnd%0d_addr", n), a, ma);
         chk($sformatf("rnd%0d_frame", n), f, (ma == BINS - 1) ? 1 : 0);
         chk($sformatf("rnd%0d_samples", n), starts - base_s, UP);
         base_s = starts;
         hm[ma] = nv;
         ma = (ma + 1) % BINS;
      end

      chk("start_hold_after_busy", v_hold, 0);
      chk("pulse_widths", v_width, 0);
      chk("read_to_write_latency", v_lat, 0);
      chk("addr_stable", v_addr, 0);
      chk("start_overlap", v_mix, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
